req_arbiter_4: RTL and testbench
================================

# req_arbiter_4

Four-channel request capture and arbitration stage that sits directly upstream of the 4x2 encoder. It edge-detects four request lines and holds them as pending. It then issues exactly one one-hot grant at a time; the grant vector drives the encoder's `din` and the encoder's `en`. Each grant is held until the consumer acknowledges it or a timeout expires.

## Interface
- `ACK_TIMEOUT`, default 15: maximum cycles a grant is held without `gnt_ack`. Legal range is 1..255; the counter is 8 bits.

- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `en`  input  1  arbitration enable; when low, no new grant is issued.
- `req`  input  4  request levels; a 0->1 transition sets the matching pending bit.
- `gnt_ack`  input  1  consumer accepts the current grant.
- `gnt`  output  4  registered one-hot grant; 4'b0000 when no grant is active.
- `gnt_valid`  output  1  high while `gnt` is non-zero.
- `pending`  output  4  registered pending-request vector.
- `timeout`  output  1  one-cycle pulse when a grant is dropped without an ack.

## Operation
- Reset values:
  - all outputs are 0;
  - internal `req_d` = 0, `ptr` = 0, timer = 0, state = IDLE.
  - Because `req_d` resets to 0, a `req` bit that is high at reset release is treated as a rising edge.
- Edge detect: `rise = req & ~req_d`, and `req_d <= req` every cycle.
- Pending update:
  - `pending <= (pending & ~clr) | rise`, where `clr` is the one-hot of the acknowledged index.
  - If `rise` and `clr` hit the same bit in the same cycle, set wins and the bit stays 1.
- Selection in round-robin mode:
  - Scan `pending` starting at index `ptr` and moving upward, modulo 4.
  - The first set bit is index k.
- State machine, two states:
  - IDLE: if `en` and `|pending`, register `gnt` = one-hot(k), `gnt_valid` = 1, timer = 0, and move to GRANT. `gnt_ack` is ignored in IDLE.
  - GRANT, ack case: if `gnt_ack`, clear `pending[k]`, set `ptr` = k+1 mod 4, set `gnt` = 0 and `gnt_valid` = 0, and move to IDLE.
  - GRANT, timeout case: else if timer == `ACK_TIMEOUT`-1, set `gnt` = 0 and `gnt_valid` = 0, pulse `timeout` for one cycle, keep `pending[k]` set, set `ptr` = k+1 mod 4 (starvation avoidance), and move to IDLE.
  - GRANT, otherwise: increment the timer.
  - If `gnt_ack` arrives in the same cycle the timeout fires, the ack wins.
- `en` falling during GRANT does not abort the grant; it completes by ack or by timeout.
- Pending capture continues regardless of `en`.
- k is latched on entry to GRANT. Pending changes during GRANT do not alter `gnt`.

## Timing
- `req` is first sampled high at edge E0; `pending` sets at E0. `gnt`/`gnt_valid` assert at E1, one cycle later, provided the block is IDLE with `en`=1.
- `gnt_ack` sampled high at edge En: `gnt` clears and `pending[k]` clears at En.
- After an ack, the earliest next grant is the following edge; the block spends one IDLE cycle.
- Maximum grant rate is therefore one per 2 cycles.
- Without an ack, `gnt_valid` stays high for exactly `ACK_TIMEOUT` cycles. `timeout` is high for the single cycle after `gnt` drops.
- Asserting `rst_n` low mid-operation clears every output and all state immediately, without waiting for a clock edge.
- Deassertion of `rst_n` is expected to be synchronized externally.

## Configuration
- Macro `ARB_FIXED_PRIORITY_EN`.
- Defined: selection always picks the lowest set index of `pending`, matching the priority order of the downstream encoder. `ptr` is not implemented.
- Undefined (default): round-robin selection as described above.
- All other behaviour is identical in both builds, including timeout handling.

## Test plan
- Single request:
  - Drive `req` = 4'b0001 for one cycle. `pending` = 0001 and then `gnt` = 0001 with `gnt_valid` = 1, one cycle apart.
  - Ack in the next cycle. `gnt` = 0000 and `pending` = 0000 on the same edge.
- Round-robin ordering:
  - Drive `req` = 4'b1111, then ack each grant immediately. Grants come out as 0001, 0010, 0100, 1000.
  - Re-pulse `req[0]` after its ack. Round-robin grants it after 1000; the `ARB_FIXED_PRIORITY_EN` build grants 0001 immediately after the current ack.
- Timeout:
  - With `ACK_TIMEOUT` = 4, `pending` = 0011 and no ack: `gnt` = 0001 for exactly 4 cycles, then one `timeout` pulse.
  - `pending` stays 0011 and the next grant is 0010.
- Enable gating:
  - With `en` = 0, pulse `req[2]` and `req[3]`. `pending` = 1100 and `gnt` stays 0000.
  - Raise `en` = 1. The next grant is 0100.
- Simultaneous set and clear: ack grant 0010 in the same cycle as a new rise on `req[1]`. `pending[1]` remains 1 and 0010 is granted again later.
- Reset mid-grant: pull `rst_n` low while `gnt` = 1000. `gnt`, `gnt_valid`, `pending` and `timeout` are 0 before the next clock edge.

Source files
------------

// File: rtl/req_arbiter_4_if.sv
`default_nettype none
// ============================================================================
// Module      : req_arbiter_4_if
// Description : Request/grant bundle between a requester-side driver and the
//               four-channel arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface req_arbiter_4_if;
    logic       en;
    logic [3:0] req;
    logic       gnt_ack;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [3:0] pending;
    logic       timeout;

    modport master (
        output en, req, gnt_ack,
        input  gnt, gnt_valid, pending, timeout
    );

    modport slave (
        input  en, req, gnt_ack,
        output gnt, gnt_valid, pending, timeout
    );
endinterface
`default_nettype wire

// File: rtl/req_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module      : req_arbiter_4
// Description : Edge-captured four-way request arbiter issuing one held,
//               one-hot grant at a time with ack/timeout release.
//               ARB_FIXED_PRIORITY_EN selects lowest-index priority instead
//               of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module req_arbiter_4 #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    req_arbiter_4_if.slave  bus
);

    localparam logic [7:0] c_timer_last = 8'(ACK_TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_req_d;
    logic [3:0] r_pending;
    logic [3:0] r_gnt;
    logic       r_gnt_valid;
    logic       r_timeout;
    logic [7:0] r_timer;
    logic [1:0] w_sel_idx;
    logic       w_grant;
    logic       w_ack;
    logic       w_drop_to;
    logic [3:0] w_rise;
    logic [3:0] w_clr;

    assign w_rise = bus.req & ~r_req_d;
    // r_gnt already is the one-hot of the granted index
    assign w_clr  = w_ack ? r_gnt : 4'b0000;

`ifdef ARB_FIXED_PRIORITY_EN
    always_comb begin
        w_sel_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (r_pending[i]) w_sel_idx = 2'(i);
        end
    end
`else
    logic [1:0] r_ptr;
    logic [1:0] r_idx;

    // Descending scan so the closest set bit at/after r_ptr is written last
    always_comb begin
        w_sel_idx = r_ptr;
        for (int i = 3; i >= 0; i--) begin
            if (r_pending[r_ptr + 2'(i)]) w_sel_idx = r_ptr + 2'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 2'd0;
            r_idx <= 2'd0;
        end else begin
            if (w_grant)               r_idx <= w_sel_idx;
            if (w_ack || w_drop_to)    r_ptr <= r_idx + 2'd1;
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_ack       = 1'b0;
        w_drop_to   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.en && (|r_pending)) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (bus.gnt_ack) begin
                    w_ack       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_timer == c_timer_last) begin
                    w_drop_to   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_req_d     <= 4'b0000;
            r_pending   <= 4'b0000;
            r_gnt       <= 4'b0000;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
            r_timer     <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_req_d   <= bus.req;
            r_pending <= (r_pending & ~w_clr) | w_rise;
            r_timeout <= w_drop_to;
            if (w_grant) begin
                r_gnt       <= 4'b0001 << w_sel_idx;
                r_gnt_valid <= 1'b1;
                r_timer     <= 8'd0;
            end else if (w_ack || w_drop_to) begin
                r_gnt       <= 4'b0000;
                r_gnt_valid <= 1'b0;
            end else if (r_state == ST_GRANT) begin
                r_timer     <= r_timer + 8'd1;
            end
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.gnt_valid = r_gnt_valid;
    assign bus.pending   = r_pending;
    assign bus.timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_req_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module      : tb_req_arbiter_4
// Description : Directed and randomized checks of req_arbiter_4 against a
//               cycle-level owner/hold-count reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_req_arbiter_4;

    localparam int TO = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    req_arbiter_4_if bus();

    req_arbiter_4 #(.ACK_TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: who owns the grant, how many cycles it has been shown,
    // where the next search begins.
    logic [3:0] m_pend;
    logic [3:0] m_req_prev;
    int         m_owner;
    int         m_held;
    int         m_start;
    logic       m_to;

    function automatic int pick_owner();
        int start;
`ifdef ARB_FIXED_PRIORITY_EN
        start = 0;
`else
        start = m_start;
`endif
        for (int off = 0; off < 4; off++) begin
            if (m_pend[(start + off) % 4]) return (start + off) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_pend = 4'b0; m_req_prev = 4'b0; m_owner = -1;
        m_held = 0; m_start = 0; m_to = 1'b0;
    endtask

    task automatic model_step(input logic en, input logic [3:0] req, input logic ack);
        logic [3:0] rise;
        logic [3:0] clr;
        rise = req & ~m_req_prev;
        m_req_prev = req;
        clr = 4'b0;
        m_to = 1'b0;
        if (m_owner < 0) begin
            if (en && m_pend != 4'b0) begin
                m_owner = pick_owner();
                m_held  = 1;
            end
        end else if (ack) begin
            clr[m_owner] = 1'b1;
            m_start = (m_owner + 1) % 4;
            m_owner = -1;
        end else if (m_held == TO) begin
            m_to    = 1'b1;
            m_start = (m_owner + 1) % 4;
            m_owner = -1;
        end else begin
            m_held++;
        end
        m_pend = (m_pend & ~clr) | rise;
    endtask

    task automatic compare_all(input string tag);
        logic [3:0] eg;
        eg = (m_owner < 0) ? 4'b0 : (4'b0001 << m_owner);
        chk($sformatf("%s.gnt", tag),       32'(bus.gnt),       32'(eg));
        chk($sformatf("%s.gnt_valid", tag), 32'(bus.gnt_valid), 32'(m_owner >= 0));
        chk($sformatf("%s.pending", tag),   32'(bus.pending),   32'(m_pend));
        chk($sformatf("%s.timeout", tag),   32'(bus.timeout),   32'(m_to));
    endtask

    task automatic cyc(input string tag, input logic en, input logic [3:0] req, input logic ack);
        @(negedge clk);
        bus.en = en; bus.req = req; bus.gnt_ack = ack;
        @(posedge clk);
        model_step(en, req, ack);
        #1;
        compare_all(tag);
    endtask

    // Assert mid-cycle to exercise the asynchronous clear, release on a negedge
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        bus.en = 1'b0; bus.req = 4'b0; bus.gnt_ack = 1'b0;
        model_reset();
        #1;
        compare_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] rl;
        logic [3:0] rr_exp [5];
        logic [3:0] to_next;
        int         cnt;

`ifdef ARB_FIXED_PRIORITY_EN
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0001;
        rr_exp[3] = 4'b0100; rr_exp[4] = 4'b1000;
        to_next   = 4'b0001;
`else
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
        to_next   = 4'b0010;
`endif
        bus.en = 1'b0; bus.req = 4'b0; bus.gnt_ack = 1'b0;
        model_reset();
        do_reset("reset");

        // Single request
        cyc("single_req", 1'b1, 4'b0001, 1'b0);
        chk("single_pend", 32'(bus.pending), 32'h1);
        cyc("single_gnt", 1'b1, 4'b0000, 1'b0);
        chk("single_gnt_val", 32'(bus.gnt), 32'h1);
        cyc("single_ack", 1'b1, 4'b0000, 1'b1);
        chk("single_ack_gnt", 32'(bus.gnt), 32'h0);

        // Ordering with a re-pulse of req[0] during the second grant
        do_reset("rr_rst");
        cyc("rr_req", 1'b1, 4'b1111, 1'b0);
        for (int n = 0; n < 5; n++) begin
            cyc("rr_gnt", 1'b1, (n == 1) ? 4'b0001 : 4'b0000, 1'b0);
            chk($sformatf("rr_order%0d", n), 32'(bus.gnt), 32'(rr_exp[n]));
            cyc("rr_ack", 1'b1, 4'b0000, 1'b1);
        end

        // Timeout
        do_reset("to_rst");
        cyc("to_req", 1'b1, 4'b0011, 1'b0);
        cyc("to_gnt", 1'b1, 4'b0000, 1'b0);
        cnt = bus.gnt_valid ? 1 : 0;
        for (int k = 0; k < 20 && bus.gnt_valid; k++) begin
            cyc("to_hold", 1'b1, 4'b0000, 1'b0);
            if (bus.gnt_valid) cnt++;
        end
        chk("to_len", 32'(cnt), 32'(TO));
        chk("to_pulse", 32'(bus.timeout), 32'h1);
        chk("to_pend", 32'(bus.pending), 32'h3);
        cyc("to_next", 1'b1, 4'b0000, 1'b0);
        chk("to_next_gnt", 32'(bus.gnt), 32'(to_next));

        // Enable gating
        do_reset("en_rst");
        cyc("en_req", 1'b0, 4'b1100, 1'b0);
        for (int k = 0; k < 3; k++) cyc("en_off", 1'b0, 4'b0000, 1'b0);
        chk("en_off_gnt", 32'(bus.gnt), 32'h0);
        chk("en_off_pend", 32'(bus.pending), 32'hC);
        cyc("en_on", 1'b1, 4'b0000, 1'b0);
        chk("en_on_gnt", 32'(bus.gnt), 32'h4);

        // Simultaneous set and clear
        do_reset("sc_rst");
        cyc("sc_req", 1'b1, 4'b0010, 1'b0);
        cyc("sc_gnt", 1'b1, 4'b0000, 1'b0);
        cyc("sc_ack", 1'b1, 4'b0010, 1'b1);
        chk("sc_pend", 32'(bus.pending), 32'h2);
        cyc("sc_regnt", 1'b1, 4'b0000, 1'b0);
        chk("sc_regnt_gnt", 32'(bus.gnt), 32'h2);

        // Reset mid-grant
        do_reset("mr_rst");
        cyc("mr_req", 1'b1, 4'b1000, 1'b0);
        cyc("mr_gnt", 1'b1, 4'b0000, 1'b0);
        chk("mr_gnt_val", 32'(bus.gnt), 32'h8);
        do_reset("mid_reset");

        // Randomized traffic
        rl = 4'b0;
        for (int c = 0; c < 2000; c++) begin
            rl = rl ^ (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
            cyc("rand", ($urandom_range(0, 7) != 0), rl, ($urandom_range(0, 2) == 0));
            if (c % 500 == 499) begin
                do_reset("rand_rst");
                rl = 4'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
